// File: rtl/ysyx_23060286_wbu_pkg.sv
// Shared definitions for the ysyx_23060286 write-back unit and its scoreboard.
package ysyx_23060286_wbu_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int CNTW   = 2;
   localparam int NREG   = 1 << REG_AW;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

endpackage

// File: rtl/ysyx_23060286_wbu_sb.sv
// Outstanding-write scoreboard: per-register counters bumped on issue, retired on
// register-file writes. Optional same-cycle forwarding under YSYX_23060286_WBU_BYPASS_EN.
module ysyx_23060286_wbu_sb
   import ysyx_23060286_wbu_pkg::*;
#(
   parameter int XLEN = ysyx_23060286_wbu_pkg::XLEN,
   parameter int CNTW = ysyx_23060286_wbu_pkg::CNTW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   output logic              iss_ready,
   input  logic              ret_en,
   input  logic [REG_AW-1:0] ret_rd,
   input  logic [XLEN-1:0]   ret_data,
   input  logic [REG_AW-1:0] rs1_addr,
   input  logic [REG_AW-1:0] rs2_addr,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              rs1_fwd,
   output logic              rs2_fwd,
   output logic [XLEN-1:0]   rs1_fwd_data,
   output logic [XLEN-1:0]   rs2_fwd_data
);

   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic [CNTW-1:0] cnt [NREG];
   logic [NREG-1:1] inc_vec;
   logic [NREG-1:1] dec_vec;
   logic            iss_fire;
   logic            raw1;
   logic            raw2;

   assign iss_ready = (iss_rd == '0) || (cnt[iss_rd] != CNT_MAX);
   assign iss_fire  = iss_valid && iss_ready;

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (iss_fire && (iss_rd != '0)) inc_vec[iss_rd] = 1'b1;
      if (ret_en && (ret_rd != '0))   dec_vec[ret_rd] = 1'b1;
   end

   // Entry 0 is never incremented or decremented, so it reads as a constant zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (inc_vec[i] && !dec_vec[i]) begin
               cnt[i] <= cnt[i] + CNTW'(1);
            end else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0)) begin
               cnt[i] <= cnt[i] - CNTW'(1);
            end
         end
      end
   end

   assign raw1 = (rs1_addr != '0) && (cnt[rs1_addr] != '0);
   assign raw2 = (rs2_addr != '0) && (cnt[rs2_addr] != '0);

`ifdef YSYX_23060286_WBU_BYPASS_EN
   logic hit1;
   logic hit2;

   // Only the last outstanding write may be forwarded; an older one would be stale.
   assign hit1 = ret_en && (ret_rd == rs1_addr) && (rs1_addr != '0) && (cnt[rs1_addr] == CNTW'(1));
   assign hit2 = ret_en && (ret_rd == rs2_addr) && (rs2_addr != '0) && (cnt[rs2_addr] == CNTW'(1));

   assign rs1_fwd      = hit1;
   assign rs2_fwd      = hit2;
   assign rs1_fwd_data = hit1 ? ret_data : '0;
   assign rs2_fwd_data = hit2 ? ret_data : '0;
   assign rs1_busy     = raw1 && !hit1;
   assign rs2_busy     = raw2 && !hit2;
`else
   logic unused_ret_data;

   assign unused_ret_data = ^ret_data;
   assign rs1_fwd      = 1'b0;
   assign rs2_fwd      = 1'b0;
   assign rs1_fwd_data = '0;
   assign rs2_fwd_data = '0;
   assign rs1_busy     = raw1;
   assign rs2_busy     = raw2;
`endif

   ret_on_idle_reg: assert property (@(posedge clk) disable iff (!rst_n)
      !(ret_en && (cnt[ret_rd] == '0)));

endmodule

// File: rtl/ysyx_23060286_wbu.sv
// Write-back unit: LSU-over-EXU arbitration onto the single register-file write port,
// plus the RAW scoreboard. Optional forwarding: YSYX_23060286_WBU_BYPASS_EN.
module ysyx_23060286_wbu
   import ysyx_23060286_wbu_pkg::*;
#(
   parameter int XLEN = ysyx_23060286_wbu_pkg::XLEN,
   parameter int CNTW = ysyx_23060286_wbu_pkg::CNTW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              exu_valid,
   output logic              exu_ready,
   input  logic [REG_AW-1:0] exu_rd,
   input  logic [XLEN-1:0]   exu_data,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [REG_AW-1:0] lsu_rd,
   input  logic [XLEN-1:0]   lsu_data,
   output logic              rf_wen,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   output logic              iss_ready,
   input  logic [REG_AW-1:0] rs1_addr,
   input  logic [REG_AW-1:0] rs2_addr,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              rs1_fwd,
   output logic              rs2_fwd,
   output logic [XLEN-1:0]   rs1_fwd_data,
   output logic [XLEN-1:0]   rs2_fwd_data
);

   wb_req_t exu_req;
   wb_req_t lsu_req;
   wb_req_t grant_req;
   logic    grant_v;
   logic    grant_wr;

   assign lsu_ready = 1'b1;
   assign exu_ready = !lsu_valid;

   assign exu_req   = '{rd: exu_rd, data: exu_data};
   assign lsu_req   = '{rd: lsu_rd, data: lsu_data};
   assign grant_v   = (lsu_valid && lsu_ready) || (exu_valid && exu_ready);
   assign grant_req = lsu_valid ? lsu_req : exu_req;
   // x0 results complete their handshake but never reach the register file.
   assign grant_wr  = grant_v && (grant_req.rd != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_wen <= grant_wr;
         if (grant_wr) begin
            rf_waddr <= grant_req.rd;
            rf_wdata <= grant_req.data;
         end
      end
   end

   ysyx_23060286_wbu_sb #(
      .XLEN (XLEN),
      .CNTW (CNTW)
   ) u_sb (
      .clk          (clk),
      .rst_n        (rst_n),
      .iss_valid    (iss_valid),
      .iss_rd       (iss_rd),
      .iss_ready    (iss_ready),
      .ret_en       (rf_wen),
      .ret_rd       (rf_waddr),
      .ret_data     (rf_wdata),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rs1_busy     (rs1_busy),
      .rs2_busy     (rs2_busy),
      .rs1_fwd      (rs1_fwd),
      .rs2_fwd      (rs2_fwd),
      .rs1_fwd_data (rs1_fwd_data),
      .rs2_fwd_data (rs2_fwd_data)
   );

endmodule

// File: tb/tb_ysyx_23060286_wbu.sv
// Bench for ysyx_23060286_wbu: directed scenarios followed by random traffic, all checked
// against a counter/pending-write model of the write-back behaviour.
module tb_ysyx_23060286_wbu;

   localparam int CMAX = (1 << 2) - 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        exu_valid, lsu_valid, iss_valid;
   logic [4:0]  exu_rd, lsu_rd, iss_rd, rs1_addr, rs2_addr;
   logic [31:0] exu_data, lsu_data;
   logic        exu_ready, lsu_ready, rf_wen, iss_ready;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, rs1_fwd_data, rs2_fwd_data;
   logic        rs1_busy, rs2_busy, rs1_fwd, rs2_fwd;

   int          n_vec = 0;
   int          n_err = 0;
   int          cnt_m [32];
   int          owed  [32];
   logic        m_wen;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   bit          exu_acc;

   always #5 clk = ~clk;

   ysyx_23060286_wbu dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .exu_valid    (exu_valid),
      .exu_ready    (exu_ready),
      .exu_rd       (exu_rd),
      .exu_data     (exu_data),
      .lsu_valid    (lsu_valid),
      .lsu_ready    (lsu_ready),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .rf_wen       (rf_wen),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .iss_valid    (iss_valid),
      .iss_rd       (iss_rd),
      .iss_ready    (iss_ready),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rs1_busy     (rs1_busy),
      .rs2_busy     (rs2_busy),
      .rs1_fwd      (rs1_fwd),
      .rs2_fwd      (rs2_fwd),
      .rs1_fwd_data (rs1_fwd_data),
      .rs2_fwd_data (rs2_fwd_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_iss_ready(input logic [4:0] rd);
      return (rd == 5'd0) || (cnt_m[rd] != CMAX);
   endfunction

   function automatic void m_query(input logic [4:0] a, output logic b, output logic f,
                                   output logic [31:0] d);
      b = (a != 5'd0) && (cnt_m[a] != 0);
      f = 1'b0;
      d = 32'd0;
`ifdef YSYX_23060286_WBU_BYPASS_EN
      if (m_wen && (m_waddr == a) && (a != 5'd0) && (cnt_m[a] == 1)) begin
         f = 1'b1;
         d = m_wdata;
         b = 1'b0;
      end
`endif
   endfunction

   task automatic compare_all();
      logic b, f;
      logic [31:0] d;
      chk("lsu_ready", 32'(lsu_ready), 32'd1);
      chk("exu_ready", 32'(exu_ready), 32'(!lsu_valid));
      chk("rf_wen", 32'(rf_wen), 32'(m_wen));
      chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
      chk("rf_wdata", rf_wdata, m_wdata);
      chk("iss_ready", 32'(iss_ready), 32'(m_iss_ready(iss_rd)));
      m_query(rs1_addr, b, f, d);
      chk("rs1_busy", 32'(rs1_busy), 32'(b));
      chk("rs1_fwd", 32'(rs1_fwd), 32'(f));
      chk("rs1_fwd_data", rs1_fwd_data, d);
      m_query(rs2_addr, b, f, d);
      chk("rs2_busy", 32'(rs2_busy), 32'(b));
      chk("rs2_fwd", 32'(rs2_fwd), 32'(f));
      chk("rs2_fwd_data", rs2_fwd_data, d);
   endtask

   // Apply the current inputs to the model as one rising edge.
   task automatic model_update();
      bit          ir, hs_l, hs_e;
      logic [4:0]  rd;
      logic [31:0] data;
      ir   = m_iss_ready(iss_rd);
      hs_l = lsu_valid;
      hs_e = exu_valid && !lsu_valid;
      exu_acc = hs_e;
      if (iss_valid && ir && (iss_rd != 5'd0)) begin
         cnt_m[iss_rd]++;
         owed[iss_rd]++;
      end
      if (m_wen && (cnt_m[m_waddr] > 0)) cnt_m[m_waddr]--;
      if (hs_l || hs_e) begin
         rd   = hs_l ? lsu_rd : exu_rd;
         data = hs_l ? lsu_data : exu_data;
         m_wen = (rd != 5'd0);
         if (rd != 5'd0) begin
            m_waddr = rd;
            m_wdata = data;
            owed[rd]--;
         end
      end else begin
         m_wen = 1'b0;
      end
   endtask

   task automatic cycle();
      #3;
      compare_all();
      model_update();
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset asserted away from the clock edge, released one cycle later.
   task automatic do_reset();
      rst_n = 1'b0;
      iss_valid = 1'b0;
      exu_valid = 1'b0;
      lsu_valid = 1'b1;
      lsu_rd = 5'd3;
      iss_rd = 5'd7;
      rs1_addr = 5'd5;
      rs2_addr = 5'd9;
      #1;
      for (int i = 0; i < 32; i++) begin
         cnt_m[i] = 0;
         owed[i] = 0;
      end
      m_wen = 1'b0;
      m_waddr = 5'd0;
      m_wdata = 32'd0;
      exu_acc = 1'b0;
      chk("rst_rf_wen", 32'(rf_wen), 32'd0);
      chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_rs1_busy", 32'(rs1_busy), 32'd0);
      chk("rst_rs2_busy", 32'(rs2_busy), 32'd0);
      chk("rst_rs1_fwd", 32'(rs1_fwd), 32'd0);
      chk("rst_rs2_fwd_data", rs2_fwd_data, 32'd0);
      chk("rst_iss_ready", 32'(iss_ready), 32'd1);
      chk("rst_exu_ready", 32'(exu_ready), 32'd0);
      chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
      @(posedge clk);
      #1;
      lsu_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   function automatic logic [4:0] pick_rd(input logic [4:0] excl_rd, input bit excl_v,
                                          output bit ok);
      int q[$];
      for (int r = 1; r < 32; r++) begin
         if (owed[r] - ((excl_v && (int'(excl_rd) == r)) ? 1 : 0) > 0) q.push_back(r);
      end
      if ((q.size() == 0) || ($urandom_range(0, 19) == 0)) begin
         ok = ($urandom_range(0, 3) == 0);
         return 5'd0;
      end
      ok = 1'b1;
      return 5'(q[$urandom_range(0, q.size() - 1)]);
   endfunction

   initial begin
      logic [4:0] r;
      bit         ok;
      exu_valid = 0; lsu_valid = 0; iss_valid = 0;
      exu_rd = 0; lsu_rd = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
      exu_data = 0; lsu_data = 0;
      @(posedge clk);
      #1;
      do_reset();

      // Single EXU write-back, one cycle of rf_wen.
      iss_valid = 1; iss_rd = 5'd5; rs1_addr = 5'd5; rs2_addr = 5'd0;
      cycle();
      iss_valid = 0;
      chk("busy_after_issue", 32'(rs1_busy), 32'd1);
      exu_valid = 1; exu_rd = 5'd5; exu_data = 32'h1234;
      cycle();
      exu_valid = 0;
      chk("exu_wen", 32'(rf_wen), 32'd1);
      chk("exu_waddr", 32'(rf_waddr), 32'd5);
      chk("exu_wdata", rf_wdata, 32'h1234);
      cycle();
      chk("wen_one_cycle", 32'(rf_wen), 32'd0);
      chk("busy_cleared", 32'(rs1_busy), 32'd0);

      // LSU and EXU together: LSU first, EXU held then written.
      iss_valid = 1; iss_rd = 5'd3; cycle();
      iss_rd = 5'd4; cycle();
      iss_valid = 0;
      lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'hAA;
      exu_valid = 1; exu_rd = 5'd4; exu_data = 32'hBB;
      #1;
      chk("exu_stalled", 32'(exu_ready), 32'd0);
      cycle();
      lsu_valid = 0;
      chk("lsu_first_addr", 32'(rf_waddr), 32'd3);
      chk("lsu_first_data", rf_wdata, 32'hAA);
      cycle();
      exu_valid = 0;
      chk("exu_second_addr", 32'(rf_waddr), 32'd4);
      chk("exu_second_data", rf_wdata, 32'hBB);
      cycle();

      // Counter saturation and same-cycle issue plus retire.
      iss_valid = 1; iss_rd = 5'd7;
      repeat (3) cycle();
      chk("iss_full", 32'(iss_ready), 32'd0);
      iss_valid = 0; exu_valid = 1; exu_rd = 5'd7; exu_data = $urandom;
      cycle();
      exu_data = $urandom;
      cycle();
      exu_valid = 0; iss_valid = 1;
      cycle();
      iss_valid = 0; rs1_addr = 5'd7;
      #1;
      chk("cnt_two_busy", 32'(rs1_busy), 32'd1);
      chk("cnt_two_ready", 32'(iss_ready), 32'd1);
      exu_valid = 1; cycle();
      exu_valid = 0; cycle();
      chk("cnt_one_busy", 32'(rs1_busy), 32'd1);
      exu_valid = 1; cycle();
      exu_valid = 0; cycle();
      chk("cnt_zero_busy", 32'(rs1_busy), 32'd0);

      // Write to x0.
      exu_valid = 1; exu_rd = 5'd0; exu_data = 32'h55; rs1_addr = 5'd0;
      #1;
      chk("x0_ready", 32'(exu_ready), 32'd1);
      cycle();
      exu_valid = 0;
      chk("x0_no_wen", 32'(rf_wen), 32'd0);
      chk("x0_not_busy", 32'(rs1_busy), 32'd0);

      // Forwarding window on rs2.
      iss_valid = 1; iss_rd = 5'd9; cycle();
      iss_valid = 0; exu_valid = 1; exu_rd = 5'd9; exu_data = 32'hDEAD; rs2_addr = 5'd9;
      cycle();
      exu_valid = 0;
`ifdef YSYX_23060286_WBU_BYPASS_EN
      chk("fwd_busy", 32'(rs2_busy), 32'd0);
      chk("fwd_valid", 32'(rs2_fwd), 32'd1);
      chk("fwd_data", rs2_fwd_data, 32'hDEAD);
`else
      chk("nofwd_busy", 32'(rs2_busy), 32'd1);
      chk("nofwd_valid", 32'(rs2_fwd), 32'd0);
      chk("nofwd_data", rs2_fwd_data, 32'd0);
`endif
      cycle();
      chk("fwd_after_busy", 32'(rs2_busy), 32'd0);

      // Reset while a write-back is in flight.
      iss_valid = 1; iss_rd = 5'd6; cycle();
      iss_valid = 0; exu_valid = 1; exu_rd = 5'd6; exu_data = 32'h6666;
      cycle();
      exu_valid = 0;
      chk("pre_reset_wen", 32'(rf_wen), 32'd1);
      do_reset();
      cycle();

      // Random traffic; results only for registers with an outstanding issue.
      exu_valid = 0;
      exu_acc = 0;
      for (int it = 0; it < 3000; it++) begin
         if (it == 1500) do_reset();
         if (exu_acc) exu_valid = 0;
         lsu_valid = 0;
         if ($urandom_range(0, 2) == 0) begin
            r = pick_rd(exu_rd, exu_valid, ok);
            if (ok) begin
               lsu_valid = 1; lsu_rd = r; lsu_data = $urandom;
            end
         end
         if (!exu_valid && ($urandom_range(0, 1) == 1)) begin
            r = pick_rd(lsu_rd, lsu_valid, ok);
            if (ok) begin
               exu_valid = 1; exu_rd = r; exu_data = $urandom;
            end
         end
         iss_valid = 1'($urandom_range(0, 1));
         iss_rd    = 5'($urandom_range(0, 7));
         rs1_addr  = 5'($urandom_range(0, 8));
         rs2_addr  = 5'($urandom_range(0, 8));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
